// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter sharing one combinational ALU
// between two requesters; result returned with a one-cycle done pulse.
module alu_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [3:0]       fs0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       fs1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_ov,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] res,
    output logic             res_ov,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       fs;
    } op_t;

    state_t state, state_nxt;
    op_t    op_q, op_sel;
    logic   last;
    logic [1:0] win;

    // last==1 means requester 1 was served most recently
    always_comb begin
        win = req;
        if (req == 2'b11)
            win = last ? 2'b01 : 2'b10;
    end

    always_comb begin
        op_sel = op_q;
        unique case (1'b1)
            win[0]:  op_sel = '{a: a0, b: b0, fs: fs0};
            win[1]:  op_sel = '{a: a1, b: b1, fs: fs1};
            default: op_sel = op_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|win) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            gnt    <= 2'b00;
            done   <= 2'b00;
            res    <= '0;
            res_ov <= 1'b0;
            last   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|win) begin
                        op_q <= op_sel;
                        gnt  <= win;
                        last <= win[1];
                    end
                end
                ISSUE: begin
                    res    <= alu_r;
                    res_ov <= alu_ov;
                    done   <= gnt;
                end
                DONE: begin
                    gnt  <= 2'b00;
                    done <= 2'b00;
                end
                default: begin
                    gnt  <= 2'b00;
                    done <= 2'b00;
                end
            endcase
        end
    end

    assign alu_a    = op_q.a;
    assign alu_b    = op_q.b;
    assign alu_func = op_q.fs;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: transaction-level reference model
// feeds an expected-result queue drained by an output monitor.
module tb_alu_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] a0, b0, fs0, a1, b1, fs1;
    logic [3:0] alu_a, alu_b, alu_func, alu_r, res;
    logic       alu_ov, res_ov, busy;
    logic [1:0] gnt, done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_sched #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .fs0(fs0),
        .a1(a1), .b1(b1), .fs1(fs1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_r(alu_r), .alu_ov(alu_ov),
        .gnt(gnt), .done(done),
        .res(res), .res_ov(res_ov), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb {alu_ov, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};

    typedef struct {
        int         cyc;
        logic [1:0] who;
        logic [3:0] r;
        logic       ov;
        logic [3:0] fs;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         hold = 0;
    logic       last_m;
    logic [1:0] cur_m;
    logic [1:0] w_m;
    logic [4:0] sum_m;
    exp_t       e_m;

    // Reference: a served request occupies the unit for three edges
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbq.delete();
            hold   = 0;
            last_m = 1'b1;
            cur_m  = 2'b00;
        end else begin
            cyc++;
            if (hold > 0) begin
                hold--;
            end else if (req != 2'b00) begin
                if (req == 2'b11) w_m = last_m ? 2'b01 : 2'b10;
                else              w_m = req;
                if (w_m == 2'b01) begin
                    sum_m   = a0 + b0;
                    e_m.fs  = fs0;
                end else begin
                    sum_m   = a1 + b1;
                    e_m.fs  = fs1;
                end
                e_m.cyc = cyc + 1;
                e_m.who = w_m;
                e_m.r   = sum_m[3:0];
                e_m.ov  = sum_m[4];
                sbq.push_back(e_m);
                last_m = (w_m == 2'b10);
                cur_m  = w_m;
                hold   = 2;
            end
        end
    end

    exp_t e_pop;

    always @(negedge clk) begin
        n_cmp++;
        if (gnt !== (hold != 0 ? cur_m : 2'b00) || busy !== (hold != 0)) begin
            n_bad++;
            $display("FAIL gnt_busy cyc=%0d: gnt=%b busy=%b want gnt=%b busy=%b",
                     cyc, gnt, busy, (hold != 0 ? cur_m : 2'b00), (hold != 0));
        end
        n_cmp++;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e_pop = sbq.pop_front();
            if (done !== e_pop.who || res !== e_pop.r ||
                res_ov !== e_pop.ov || alu_func !== e_pop.fs) begin
                n_bad++;
                $display("FAIL result cyc=%0d: done=%b res=%h ov=%b func=%h want done=%b res=%h ov=%b func=%h",
                         cyc, done, res, res_ov, alu_func,
                         e_pop.who, e_pop.r, e_pop.ov, e_pop.fs);
            end
        end else if (done !== 2'b00) begin
            n_bad++;
            $display("FAIL spurious_done cyc=%0d: done=%b want 00", cyc, done);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic reset_chk(input string nm);
        chk({nm, "_gnt"}, {30'd0, gnt}, 32'd0);
        chk({nm, "_done"}, {30'd0, done}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_res"}, {27'd0, res_ov, res}, 32'd0);
        chk({nm, "_alu"}, {20'd0, alu_a, alu_b, alu_func}, 32'd0);
    endtask

    task automatic wait_gnt(input logic [1:0] want, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt !== want && n < 20);
        if (gnt !== want) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_gnt: gnt=%b want %b", gnt, want);
        end
    endtask

    int         n;
    logic [1:0] prev_g;
    logic [1:0] gord[$];

    initial begin
        rst = 1'b1;
        req = 2'b00;
        {a0, b0, fs0, a1, b1, fs1} = '0;
        #1 rst = 1'b0;
        #1 reset_chk("reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        // single request
        @(negedge clk);
        a0 = 4'd5; b0 = 4'd3; fs0 = 4'h0; req = 2'b01;
        wait_gnt(2'b01, n);
        chk("single_lat", n, 1);
        req = 2'b00;
        @(negedge clk);
        chk("single_res", {27'd0, res_ov, res}, 32'd8);
        chk("single_done", {30'd0, done}, 32'd1);
        @(negedge clk);
        chk("single_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // overflow, operands changed right after grant
        a1 = 4'hC; b1 = 4'h7; fs1 = 4'h9; req = 2'b10;
        wait_gnt(2'b10, n);
        req = 2'b00; a1 = 4'h0; b1 = 4'h0;
        @(negedge clk);
        chk("ovf_res", {27'd0, res_ov, res}, 32'h13);
        repeat (4) @(negedge clk);

        // tie from reset
        #2 rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        #2 rst = 1'b1;
        prev_g = 2'b00;
        repeat (12) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev_g == 2'b00) gord.push_back(gnt);
            prev_g = gnt;
            a0 = 4'($urandom); b0 = 4'($urandom); fs0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); fs1 = 4'($urandom);
        end
        req = 2'b00;
        chk("tie_count", gord.size(), 4);
        for (int i = 0; i < 4 && i < gord.size(); i++)
            chk("tie_order", {30'd0, gord[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        repeat (4) @(negedge clk);

        // late request during ISSUE
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd9; b1 = 4'd9; req = 2'b01;
        wait_gnt(2'b01, n);
        req = 2'b10;
        wait_gnt(2'b10, n);
        chk("late_lat", n, 3);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // stale request re-granted
        a0 = 4'd7; b0 = 4'd7; req = 2'b01;
        wait_gnt(2'b01, n);
        repeat (3) @(negedge clk);
        chk("stale_regrant", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // reset mid-ISSUE, no done afterwards
        a0 = 4'd6; b0 = 4'd6; fs0 = 4'h5; req = 2'b01;
        wait_gnt(2'b01, n);
        #2 rst = 1'b0;
        #1 reset_chk("mid_reset");
        req = 2'b00;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);

        // random traffic
        repeat (300) begin
            @(negedge clk);
            req = 2'($urandom);
            a0 = 4'($urandom); b0 = 4'($urandom); fs0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); fs1 = 4'($urandom);
        end
        req = 2'b00;
        repeat (6) @(negedge clk);
        chk("drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
